// File: rtl/calculator_pkg.sv
// rtl/calculator_pkg.sv - shared calculator types: scheduler state and job descriptor
package calculator_pkg;

    localparam int ADDR_W = 8;

    typedef enum logic [1:0] {
        SCH_IDLE,
        SCH_LOAD,
        SCH_START,
        SCH_WAIT
    } sched_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] rd_start;
        logic [ADDR_W-1:0] rd_end;
        logic [ADDR_W-1:0] wr_start;
        logic [ADDR_W-1:0] wr_end;
    } job_desc_t;

    // Ranges are inclusive, so an empty range (end below start) is malformed.
    function automatic logic desc_is_good(input job_desc_t d);
        return (d.rd_end >= d.rd_start) && (d.wr_end >= d.wr_start);
    endfunction

endpackage

// File: rtl/calc_job_fifo.sv
// rtl/calc_job_fifo.sv - synchronous descriptor FIFO with full/empty/occupancy
module calc_job_fifo
    import calculator_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  job_desc_t              push_data_i,
    input  logic                   pop_i,
    output job_desc_t              pop_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    job_desc_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign pop_data_o = mem_q[rd_ptr_q];

    // A full FIFO refuses a push even when a pop happens in the same cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/calc_job_scheduler.sv
// rtl/calc_job_scheduler.sv - queues host job descriptors and launches them on the calculator controller
module calc_job_scheduler #(
    parameter int ADDR_W  = calculator_pkg::ADDR_W,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   job_valid_i,
    output logic                   job_ready_o,
    input  logic [ADDR_W-1:0]      job_rd_start_i,
    input  logic [ADDR_W-1:0]      job_rd_end_i,
    input  logic [ADDR_W-1:0]      job_wr_start_i,
    input  logic [ADDR_W-1:0]      job_wr_end_i,
    output logic [ADDR_W-1:0]      read_start_addr_o,
    output logic [ADDR_W-1:0]      read_end_addr_o,
    output logic [ADDR_W-1:0]      write_start_addr_o,
    output logic [ADDR_W-1:0]      write_end_addr_o,
    output logic                   ctrl_start_o,
    output logic                   ctrl_abort_o,
    input  logic                   ctrl_done_i,
    output logic                   busy_o,
    output logic [$clog2(DEPTH):0] pending_o,
    output logic [7:0]             jobs_done_o,
    output logic [1:0]             err_o,
    input  logic                   err_clr_i
);

    import calculator_pkg::*;

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int WD_W  = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    job_desc_t         job_in;
    job_desc_t         fifo_head;
    logic              fifo_full, fifo_empty, fifo_pop;
    logic [CNT_W-1:0]  fifo_count;
    logic              job_accept, job_push, job_bad;
    logic              done_evt, wd_expire;

    sched_state_t      state_q;
    logic [WD_W-1:0]   wdog_q;
    logic [ADDR_W-1:0] rd_start_q, rd_end_q, wr_start_q, wr_end_q;
    logic              ctrl_start_q, ctrl_abort_q;
    logic [7:0]        jobs_done_q;
    logic [1:0]        err_q, err_d;

    assign job_in = '{rd_start: job_rd_start_i,
                      rd_end:   job_rd_end_i,
                      wr_start: job_wr_start_i,
                      wr_end:   job_wr_end_i};

    assign job_ready_o = !fifo_full;
    assign job_accept  = job_valid_i && job_ready_o;
    assign job_push    = job_accept && desc_is_good(job_in);
    assign job_bad     = job_accept && !desc_is_good(job_in);
    assign fifo_pop    = (state_q == SCH_LOAD);

    // Completion takes priority over the watchdog in the final WAIT cycle.
    assign done_evt  = (state_q == SCH_WAIT) && ctrl_done_i;
    assign wd_expire = (state_q == SCH_WAIT) && !ctrl_done_i && (wdog_q == WD_LAST);

    calc_job_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (job_push),
        .push_data_i (job_in),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= SCH_IDLE;
            wdog_q       <= '0;
            rd_start_q   <= '0;
            rd_end_q     <= '0;
            wr_start_q   <= '0;
            wr_end_q     <= '0;
            ctrl_start_q <= 1'b0;
            ctrl_abort_q <= 1'b0;
            jobs_done_q  <= '0;
        end else begin
            ctrl_start_q <= 1'b0;
            ctrl_abort_q <= 1'b0;
            case (state_q)
                SCH_IDLE: begin
                    if (!fifo_empty) begin
                        state_q <= SCH_LOAD;
                    end
                end
                SCH_LOAD: begin
                    rd_start_q   <= fifo_head.rd_start;
                    rd_end_q     <= fifo_head.rd_end;
                    wr_start_q   <= fifo_head.wr_start;
                    wr_end_q     <= fifo_head.wr_end;
                    ctrl_start_q <= 1'b1;
                    state_q      <= SCH_START;
                end
                SCH_START: begin
                    wdog_q  <= '0;
                    state_q <= SCH_WAIT;
                end
                SCH_WAIT: begin
                    if (done_evt) begin
                        jobs_done_q <= jobs_done_q + 8'd1;
                        state_q     <= fifo_empty ? SCH_IDLE : SCH_LOAD;
                    end else if (wd_expire) begin
                        ctrl_abort_q <= 1'b1;
                        state_q      <= SCH_IDLE;
                    end else begin
                        wdog_q <= wdog_q + WD_W'(1);
                    end
                end
                default: state_q <= SCH_IDLE;
            endcase
        end
    end

    always_comb begin
        err_d = err_clr_i ? 2'b00 : err_q;
        if (job_bad) begin
            err_d[0] = 1'b1;
        end
        if (wd_expire) begin
            err_d[1] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 2'b00;
        end else begin
            err_q <= err_d;
        end
    end

    assign read_start_addr_o  = rd_start_q;
    assign read_end_addr_o    = rd_end_q;
    assign write_start_addr_o = wr_start_q;
    assign write_end_addr_o   = wr_end_q;
    assign ctrl_start_o       = ctrl_start_q;
    assign ctrl_abort_o       = ctrl_abort_q;
    assign busy_o             = (state_q != SCH_IDLE);
    assign pending_o          = fifo_count;
    assign jobs_done_o        = jobs_done_q;
    assign err_o              = err_q;

endmodule

// File: tb/tb_calc_job_scheduler.sv
// tb/tb_calc_job_scheduler.sv - directed vector bench for calc_job_scheduler
module tb_calc_job_scheduler;

    localparam int AW      = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;
    localparam int NV      = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          job_valid = 1'b0;
    logic          job_ready;
    logic [AW-1:0] job_rd_start = '0, job_rd_end = '0, job_wr_start = '0, job_wr_end = '0;
    logic [AW-1:0] rd_start_o, rd_end_o, wr_start_o, wr_end_o;
    logic          ctrl_start, ctrl_abort;
    logic          ctrl_done = 1'b0;
    logic          busy;
    logic [2:0]    pending;
    logic [7:0]    jobs_done;
    logic [1:0]    err;
    logic          err_clr = 1'b0;

    int nvec = 0;
    int nerr = 0;
    int exp_done = 0;

    typedef struct {
        logic [31:0] d;
        logic        good;
    } vec_t;

    vec_t        vecs [NV];
    logic [31:0] jq [6];
    logic [31:0] last_rng;

    calc_job_scheduler #(
        .ADDR_W  (AW),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .job_valid_i        (job_valid),
        .job_ready_o        (job_ready),
        .job_rd_start_i     (job_rd_start),
        .job_rd_end_i       (job_rd_end),
        .job_wr_start_i     (job_wr_start),
        .job_wr_end_i       (job_wr_end),
        .read_start_addr_o  (rd_start_o),
        .read_end_addr_o    (rd_end_o),
        .write_start_addr_o (wr_start_o),
        .write_end_addr_o   (wr_end_o),
        .ctrl_start_o       (ctrl_start),
        .ctrl_abort_o       (ctrl_abort),
        .ctrl_done_i        (ctrl_done),
        .busy_o             (busy),
        .pending_o          (pending),
        .jobs_done_o        (jobs_done),
        .err_o              (err),
        .err_clr_i          (err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL sim_timeout: bench did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_job(input logic [31:0] d);
        job_rd_start = d[31:24];
        job_rd_end   = d[23:16];
        job_wr_start = d[15:8];
        job_wr_end   = d[7:0];
    endtask

    function automatic logic [31:0] ranges();
        return {rd_start_o, rd_end_o, wr_start_o, wr_end_o};
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, "_ranges"},  ranges(), 32'h0);
        chk({tag, "_start"},   32'(ctrl_start), 32'd0);
        chk({tag, "_abort"},   32'(ctrl_abort), 32'd0);
        chk({tag, "_busy"},    32'(busy), 32'd0);
        chk({tag, "_pending"}, 32'(pending), 32'd0);
        chk({tag, "_done"},    32'(jobs_done), 32'd0);
        chk({tag, "_err"},     32'(err), 32'd0);
        chk({tag, "_ready"},   32'(job_ready), 32'd1);
    endtask

    initial begin
        vecs[0] = '{32'h00_09_10_14, 1'b1};
        vecs[1] = '{32'h05_05_07_07, 1'b1};
        vecs[2] = '{32'h00_FF_00_FF, 1'b1};
        vecs[3] = '{32'h08_03_10_14, 1'b0};
        vecs[4] = '{32'h00_09_14_10, 1'b0};
        vecs[5] = '{32'hFF_00_00_00, 1'b0};
        vecs[6] = '{32'hC8_C9_64_96, 1'b1};
        jq[0] = 32'h01020304;
        jq[1] = 32'h11121314;
        jq[2] = 32'h21222324;
        jq[3] = 32'h31323334;
        jq[4] = 32'h41424344;
        jq[5] = 32'h51525354;
        last_rng = 32'h0;

        #2 rst_n = 1'b0;
        tick();
        check_reset("rst");
        tick();
        rst_n = 1'b1;
        tick();

        // Single descriptors from IDLE: good ones launch, bad ones flag err[0].
        for (int i = 0; i < NV; i++) begin
            set_job(vecs[i].d);
            job_valid = 1'b1;
            chk("v_ready", 32'(job_ready), 32'd1);
            tick();
            job_valid = 1'b0;
            if (vecs[i].good) begin
                chk("v_pending1", 32'(pending), 32'd1);
                chk("v_err_clean", 32'(err), 32'd0);
                tick();
                chk("v_load_busy", 32'(busy), 32'd1);
                chk("v_load_nostart", 32'(ctrl_start), 32'd0);
                tick();
                chk("v_start", 32'(ctrl_start), 32'd1);
                chk("v_ranges", ranges(), vecs[i].d);
                chk("v_popped", 32'(pending), 32'd0);
                last_rng = vecs[i].d;
                tick();
                chk("v_start_pulse", 32'(ctrl_start), 32'd0);
                repeat (3) tick();
                ctrl_done = 1'b1;
                tick();
                ctrl_done = 1'b0;
                exp_done++;
                chk("v_jobs_done", 32'(jobs_done), 32'(exp_done));
                chk("v_idle", 32'(busy), 32'd0);
            end else begin
                chk("v_bad_err", 32'(err), 32'd1);
                chk("v_bad_pending", 32'(pending), 32'd0);
                tick();
                tick();
                chk("v_bad_busy", 32'(busy), 32'd0);
                chk("v_bad_nostart", 32'(ctrl_start), 32'd0);
                chk("v_bad_held", ranges(), last_rng);
                err_clr = 1'b1;
                tick();
                err_clr = 1'b0;
                chk("v_err_clr", 32'(err), 32'd0);
            end
        end

        // Fill the FIFO behind a running job, hold a fifth, drain back-to-back.
        set_job(jq[0]);
        job_valid = 1'b1;
        tick();
        job_valid = 1'b0;
        tick();
        tick();
        chk("q_start0", 32'(ctrl_start), 32'd1);
        chk("q_rng0", ranges(), jq[0]);
        tick();
        for (int k = 1; k <= 4; k++) begin
            set_job(jq[k]);
            job_valid = 1'b1;
            tick();
            chk("q_fill", 32'(pending), 32'(k));
        end
        set_job(jq[5]);
        chk("q_full_ready", 32'(job_ready), 32'd0);
        tick();
        chk("q_held1", 32'(pending), 32'd4);
        tick();
        chk("q_held2", 32'(pending), 32'd4);
        job_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            ctrl_done = 1'b1;
            tick();
            ctrl_done = 1'b0;
            exp_done++;
            chk("q_done", 32'(jobs_done), 32'(exp_done));
            tick();
            chk("q_start", 32'(ctrl_start), 32'd1);
            chk("q_rng", ranges(), jq[k]);
            chk("q_pending", 32'(pending), 32'(4 - k));
            chk("q_ready", 32'(job_ready), 32'd1);
            tick();
        end
        ctrl_done = 1'b1;
        tick();
        ctrl_done = 1'b0;
        exp_done++;
        chk("q_done_last", 32'(jobs_done), 32'(exp_done));
        chk("q_idle", 32'(busy), 32'd0);
        tick();
        chk("q_no_extra", 32'(ctrl_start), 32'd0);

        // Watchdog abort, then the queued job launches and finishes on the last cycle.
        set_job(32'h0A0B0C0D);
        job_valid = 1'b1;
        tick();
        set_job(32'h14151617);
        tick();
        job_valid = 1'b0;
        tick();
        chk("t_start1", 32'(ctrl_start), 32'd1);
        chk("t_rng1", ranges(), 32'h0A0B0C0D);
        chk("t_pending", 32'(pending), 32'd1);
        tick();
        repeat (TIMEOUT - 1) tick();
        chk("t_no_abort_yet", 32'(ctrl_abort), 32'd0);
        chk("t_still_busy", 32'(busy), 32'd1);
        tick();
        chk("t_abort", 32'(ctrl_abort), 32'd1);
        chk("t_err", 32'(err), 32'd2);
        chk("t_not_counted", 32'(jobs_done), 32'(exp_done));
        chk("t_idle", 32'(busy), 32'd0);
        tick();
        chk("t_abort_pulse", 32'(ctrl_abort), 32'd0);
        tick();
        chk("t_start2", 32'(ctrl_start), 32'd1);
        chk("t_rng2", ranges(), 32'h14151617);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t_err_clr", 32'(err), 32'd0);
        repeat (TIMEOUT - 2) tick();
        ctrl_done = 1'b1;
        tick();
        ctrl_done = 1'b0;
        exp_done++;
        chk("d_counted", 32'(jobs_done), 32'(exp_done));
        chk("d_no_abort", 32'(ctrl_abort), 32'd0);
        chk("d_no_err", 32'(err), 32'd0);
        chk("d_idle", 32'(busy), 32'd0);
        tick();
        chk("d_no_abort2", 32'(ctrl_abort), 32'd0);

        // Stray done in IDLE, then a bad push racing err_clr.
        ctrl_done = 1'b1;
        tick();
        ctrl_done = 1'b0;
        chk("s_stray_done", 32'(jobs_done), 32'(exp_done));
        chk("s_stray_busy", 32'(busy), 32'd0);
        tick();
        chk("s_stray_start", 32'(ctrl_start), 32'd0);
        set_job(32'h08031014);
        job_valid = 1'b1;
        err_clr = 1'b1;
        tick();
        job_valid = 1'b0;
        err_clr = 1'b0;
        chk("s_set_wins", 32'(err), 32'd1);
        chk("s_bad_pending", 32'(pending), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Asynchronous reset in WAIT with two jobs still queued.
        for (int k = 0; k < 3; k++) begin
            set_job(32'h30313233 + 32'(k) * 32'h01010101);
            job_valid = 1'b1;
            tick();
        end
        job_valid = 1'b0;
        tick();
        chk("r_pending2", 32'(pending), 32'd2);
        chk("r_busy", 32'(busy), 32'd1);
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        check_reset("r_async");
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("r_quiet_start", 32'(ctrl_start), 32'd0);
            chk("r_quiet_busy", 32'(busy), 32'd0);
        end
        set_job(32'h00FF00FF);
        job_valid = 1'b1;
        tick();
        job_valid = 1'b0;
        tick();
        tick();
        chk("r_start", 32'(ctrl_start), 32'd1);
        chk("r_rng", ranges(), 32'h00FF00FF);
        tick();
        ctrl_done = 1'b1;
        tick();
        ctrl_done = 1'b0;
        chk("r_done", 32'(jobs_done), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
